// File: rtl/scan_cfg_counter.sv
// scan_cfg_counter: parameterised up/down counter whose modulus, preload,
// direction and run enable are programmed through a serial scan chain in the
// counter's own clock domain. A commit strobe copies the chain fields into
// shadow config registers, so shifting a new word never disturbs counting.
module scan_cfg_counter #(
    parameter int CNT_W     = 7,
    parameter int CHAIN_LEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,      // active-high synchronous reset
    input  logic             shift_en,
    input  logic             shift_dta,
    input  logic             commit,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             tc,
    output logic             shift_out
);

    // Field positions inside the chain; bits above RUN_BIT only pass through.
    localparam int MAX_LSB  = 0;
    localparam int LOAD_LSB = CNT_W;
    localparam int DIR_BIT  = 2 * CNT_W;
    localparam int RUN_BIT  = 2 * CNT_W + 1;

    // Elaboration-time guard on the parameter set.
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("scan_cfg_counter: CNT_W must be >= 2");
    end
    if (CHAIN_LEN < 2 * CNT_W + 2) begin : g_bad_chain_len
        $error("scan_cfg_counter: CHAIN_LEN must be >= 2*CNT_W+2");
    end

    logic [CHAIN_LEN-1:0] chain_q,    chain_d;
    logic [CNT_W-1:0]     cfg_max_q,  cfg_max_d;
    logic [CNT_W-1:0]     cfg_load_q, cfg_load_d;
    logic                 cfg_dir_q,  cfg_dir_d;
    logic                 cfg_run_q,  cfg_run_d;
    logic [CNT_W-1:0]     count_q,    count_d;
    logic                 tc_q,       tc_d;

    logic                 commit_take;
    logic                 count_take;

    // A commit is only honoured on a non-shifting edge; it also blocks counting.
    assign commit_take = commit & ~shift_en;
    assign count_take  = cfg_run_q & count_en & ~commit_take;

    // Chain shift register: serial in at bit 0, MSB is the daisy-chain output.
    always_comb begin
        chain_d = chain_q;
        if (shift_en) begin
            chain_d = {chain_q[CHAIN_LEN-2:0], shift_dta};
        end
    end

    // Shadow config registers: load from the chain fields on a taken commit.
    always_comb begin
        cfg_max_d  = cfg_max_q;
        cfg_load_d = cfg_load_q;
        cfg_dir_d  = cfg_dir_q;
        cfg_run_d  = cfg_run_q;
        if (commit_take) begin
            cfg_max_d  = chain_q[MAX_LSB  +: CNT_W];
            cfg_load_d = chain_q[LOAD_LSB +: CNT_W];
            cfg_dir_d  = chain_q[DIR_BIT];
            cfg_run_d  = chain_q[RUN_BIT];
        end
    end

    // Counter and terminal-count pulse. The wrap compare comes before the
    // increment/decrement, so an out-of-range preload wraps on the first edge
    // and the arithmetic never overflows. tc defaults low so it is a 1-cycle pulse.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (commit_take) begin
            count_d = chain_q[LOAD_LSB +: CNT_W];
        end else if (count_take) begin
            if (!cfg_dir_q) begin
                if (count_q >= cfg_max_q) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                if ((count_q == '0) || (count_q > cfg_max_q)) begin
                    count_d = cfg_max_q;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset wins over shift, commit and count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            chain_q    <= '0;
            cfg_max_q  <= '0;
            cfg_load_q <= '0;
            cfg_dir_q  <= 1'b0;
            cfg_run_q  <= 1'b0;
            count_q    <= '0;
            tc_q       <= 1'b0;
        end else begin
            chain_q    <= chain_d;
            cfg_max_q  <= cfg_max_d;
            cfg_load_q <= cfg_load_d;
            cfg_dir_q  <= cfg_dir_d;
            cfg_run_q  <= cfg_run_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign shift_out = chain_q[CHAIN_LEN-1];

endmodule

// File: tb/tb_scan_cfg_counter.sv
// Directed bench for scan_cfg_counter at CNT_W=7, CHAIN_LEN=32.
module tb_scan_cfg_counter;

    localparam int CNT_W     = 7;
    localparam int CHAIN_LEN = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             shift_en;
    logic             shift_dta;
    logic             commit;
    logic             count_en;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             shift_out;

    int total = 0;
    int bad   = 0;

    scan_cfg_counter #(.CNT_W(CNT_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en),
        .shift_dta (shift_dta),
        .commit    (commit),
        .count_en  (count_en),
        .count     (count),
        .tc        (tc),
        .shift_out (shift_out)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkword(input logic run, input logic dir,
                                           input logic [6:0] load, input logic [6:0] mx);
        mkword = {16'h0000, run, dir, load, mx};
    endfunction

    task automatic shift_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            shift_en  = 1'b1;
            shift_dta = w[31-i];
            tick();
        end
        shift_en  = 1'b0;
        shift_dta = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; shift_en = 1'b0; shift_dta = 1'b0; commit = 1'b0; count_en = 1'b0;
        tick(); tick();
        total++;
        if (count !== 7'd0 || tc !== 1'b0 || shift_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: count=%0d tc=%b so=%b want 0/0/0", count, tc, shift_out);
        end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_up_count();
        shift_word(mkword(1'b1, 1'b0, 7'd0, 7'd9));
        do_commit();
        total++;
        if (count !== 7'd0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL up_commit: count=%0d tc=%b want 0/0", count, tc);
        end
        count_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (count !== 7'(i % 10) || tc !== (i == 10)) begin
                bad++;
                $display("FAIL up_seq[%0d]: count=%0d tc=%b want %0d/%b", i, count, tc, i % 10, i == 10);
            end
        end
        count_en = 1'b0;
    endtask

    task automatic test_down_hold();
        logic [6:0] exp_c [6];
        exp_c = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0, 7'd5};
        shift_word(mkword(1'b1, 1'b1, 7'd5, 7'd5));
        do_commit();
        total++;
        if (count !== 7'd5 || tc !== 1'b0) begin
            bad++;
            $display("FAIL down_commit: count=%0d tc=%b want 5/0", count, tc);
        end
        count_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (count !== exp_c[i] || tc !== (i == 5)) begin
                bad++;
                $display("FAIL down_seq[%0d]: count=%0d tc=%b want %0d/%b", i, count, tc, exp_c[i], i == 5);
            end
        end
        count_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count !== 7'd5 || tc !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: count=%0d tc=%b want 5/0", i, count, tc);
            end
        end
    endtask

    task automatic test_out_of_range();
        shift_word(mkword(1'b1, 1'b0, 7'd100, 7'd3));
        do_commit();
        total++;
        if (count !== 7'd100) begin
            bad++;
            $display("FAIL oor_up_load: count=%0d want 100", count);
        end
        count_en = 1'b1; tick(); count_en = 1'b0;
        total++;
        if (count !== 7'd0 || tc !== 1'b1) begin
            bad++;
            $display("FAIL oor_up_wrap: count=%0d tc=%b want 0/1", count, tc);
        end
        shift_word(mkword(1'b1, 1'b1, 7'd100, 7'd3));
        do_commit();
        count_en = 1'b1; tick(); count_en = 1'b0;
        total++;
        if (count !== 7'd3 || tc !== 1'b1) begin
            bad++;
            $display("FAIL oor_dn_wrap: count=%0d tc=%b want 3/1", count, tc);
        end
    endtask

    // Config now: run=1, dir=1, max=3, count=3.
    task automatic test_shadow_shift();
        logic [31:0] pat;
        pat = 32'hA5C3_0F01;
        count_en = 1'b1;
        shift_word(pat);   // 32 down-count edges from 3, period 4 -> back to 3 with tc
        total++;
        if (count !== 7'd3 || tc !== 1'b1) begin
            bad++;
            $display("FAIL shadow_count: count=%0d tc=%b want 3/1", count, tc);
        end
        tick();
        total++;
        if (count !== 7'd2 || tc !== 1'b0) begin
            bad++;
            $display("FAIL shadow_cfg: count=%0d tc=%b want 2/0", count, tc);
        end
        count_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            total++;
            if (shift_out !== pat[31-i]) begin
                bad++;
                $display("FAIL shift_out[%0d]: got %b want %b", i, shift_out, pat[31-i]);
            end
            shift_en = 1'b1; shift_dta = 1'b0;
            tick();
        end
        shift_en = 1'b1; commit = 1'b1; shift_dta = 1'b1;
        tick();
        shift_en = 1'b0; commit = 1'b0; shift_dta = 1'b0;
        total++;
        if (count !== 7'd2 || tc !== 1'b0) begin
            bad++;
            $display("FAIL commit_while_shift: count=%0d tc=%b want 2/0", count, tc);
        end
        count_en = 1'b1; tick(); count_en = 1'b0;
        total++;
        if (count !== 7'd1 || tc !== 1'b0) begin
            bad++;
            $display("FAIL cfg_kept: count=%0d tc=%b want 1/0", count, tc);
        end
    endtask

    task automatic test_max_zero();
        shift_word(mkword(1'b1, 1'b0, 7'd0, 7'd0));
        do_commit();
        count_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (count !== 7'd0 || tc !== 1'b1) begin
                bad++;
                $display("FAIL max0[%0d]: count=%0d tc=%b want 0/1", i, count, tc);
            end
        end
        count_en = 1'b0;
        shift_word(mkword(1'b0, 1'b0, 7'd6, 7'd0));
        do_commit();
        count_en = 1'b1; tick(); count_en = 1'b0;
        total++;
        if (count !== 7'd6 || tc !== 1'b0) begin
            bad++;
            $display("FAIL run_off: count=%0d tc=%b want 6/0", count, tc);
        end
    endtask

    task automatic test_reset_mid();
        shift_word(32'hFFFF_0000 | mkword(1'b1, 1'b0, 7'd0, 7'd20));
        do_commit();
        total++;
        if (shift_out !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_so: got %b want 1", shift_out);
        end
        count_en = 1'b1;
        repeat (7) tick();
        total++;
        if (count !== 7'd7) begin
            bad++;
            $display("FAIL pre_rst_count: count=%0d want 7", count);
        end
        shift_en = 1'b1; shift_dta = 1'b1; rst_n = 1'b1;
        tick();
        shift_en = 1'b0; shift_dta = 1'b0; rst_n = 1'b0;
        total++;
        if (count !== 7'd0 || tc !== 1'b0 || shift_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: count=%0d tc=%b so=%b want 0/0/0", count, tc, shift_out);
        end
        tick(); tick();
        count_en = 1'b0;
        total++;
        if (count !== 7'd0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_stop: count=%0d tc=%b want 0/0", count, tc);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_hold();
        test_out_of_range();
        test_shadow_shift();
        test_max_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
